// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit: default widths, the
// reset PC, the sequential fetch step, the fetch FSM state type and the
// {pc, instr} entry stored in the fetch buffer.
// No ports (package).
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int          ADDR_W   = 32;
    localparam int          INSTR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } ifu_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Small synchronous FIFO holding fetched {pc, instr} entries. The head entry
// is presented from a register so decode sees stable outputs; when the FIFO
// runs empty the head register keeps its last value. Flush empties the FIFO
// and dominates push and pop.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   push       in   write push_data (accepted when not full, or full with pop)
//   pop        in   remove head (ignored when empty)
//   flush      in   discard all entries
//   push_data  in   entry to write
//   head       out  registered head entry
//   valid      out  FIFO holds at least one entry
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
// ---------------------------------------------------------------------------
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t push_data,
    output entry_t head,
    output logic   valid,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               do_push;
    logic               do_pop;
    entry_t             head_next;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign valid = !empty;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push alongside a pop.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // DEPTH is a power of two, so the pointers wrap naturally.
    assign rd_ptr_next = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // The next head is either an existing entry or, when the FIFO is (or
    // becomes) empty, the entry being written this cycle. An empty FIFO
    // keeps the previous head value.
    always_comb begin
        head_next = head;
        if (count_next != '0) begin
            if (do_push && (wr_ptr == rd_ptr_next)) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // Storage array; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            count <= count_next;
            head  <= head_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr_next;
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Initiator side of the instruction-memory interface. Drives the word-aligned
// fetch PC to memory, captures the combinationally returned instruction,
// buffers {pc, instr} pairs in ifu_fifo and offers them to decode over a
// valid/ready handshake. Supports backpressure stalls, branch redirect with
// flush, and run/idle via enable_i.
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous active-low reset
//   enable_i       in   fetch permitted when high
//   addr_o         out  fetch address (always equals the fetch PC)
//   instr_i        in   instruction returned for addr_o
//   redirect_i     in   one-cycle redirect strobe
//   redirect_pc_i  in   redirect target (low two bits ignored)
//   instr_valid_o  out  head entry valid
//   instr_ready_i  in   decode accepts head
//   instr_o        out  head instruction
//   pc_o           out  head PC
//   fetch_cnt_o    out  pushes performed          (IFU_PERF_CNT_EN only)
//   stall_cnt_o    out  full, no-pop FETCH cycles (IFU_PERF_CNT_EN only)
//
// Build option: define IFU_PERF_CNT_EN to add the performance counters.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W     = ifu_pkg::ADDR_W,
    parameter int                INSTR_W    = ifu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(ifu_pkg::RESET_PC),
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    output logic [ADDR_W-1:0]  addr_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        stall_cnt_o
`endif
);

    import ifu_pkg::*;

    // Entry type sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    ifu_state_t         state;
    ifu_state_t         state_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  redirect_target;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;
    entry_t             push_entry;
    entry_t             head;

    assign addr_o          = fetch_pc;
    assign redirect_target = redirect_pc_i & ~ADDR_W'(3);

    assign pop  = instr_valid_o && instr_ready_i;
    // Redirect cancels the push; the target is fetched the following cycle.
    assign push = (state == FETCH) && !redirect_i && (!fifo_full || pop);

    assign push_entry.pc    = fetch_pc;
    assign push_entry.instr = instr_i;

    assign instr_o = head.instr;
    assign pc_o    = head.pc;

    // Run/idle follows enable_i directly; PC and buffer survive IDLE.
    always_comb begin
        state_next = enable_i ? FETCH : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch PC: redirect wins, otherwise advance by one word on every push.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= redirect_target;
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
    end

    ifu_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_i),
        .push_data (push_entry),
        .head      (head),
        .valid     (instr_valid_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef IFU_PERF_CNT_EN
    logic stall;

    assign stall = (state == FETCH) && fifo_full && !pop;

    // Free-running counters; redirect does not clear them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (push) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (stall) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

    // Emptiness is already carried by instr_valid_o.
    logic unused_empty;
    assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. A behavioural model predicts
// every push; predicted {pc, instr} pairs go into a queue and are compared
// against the head outputs as decode consumes them.
// Define IFU_PERF_CNT_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic [31:0] addr_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    int          error_count = 0;
    int          check_count = 0;

    logic [63:0] exp_q[$];
    bit          m_fetch;
    int          m_count;
    logic [31:0] m_pc;
    logic [63:0] m_hold;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_stall_cnt;

    instr_fetch_unit #(
        .ADDR_W     (32),
        .INSTR_W    (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .addr_o        (addr_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // 128-word instruction memory: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {25'd0, a[8:2]};
    endfunction

    assign instr_i = mem_word(addr_o);

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_fetch     = 1'b0;
        m_count     = 0;
        m_pc        = 32'h0000_0000;
        m_hold      = 64'd0;
        m_fetch_cnt = 32'd0;
        m_stall_cnt = 32'd0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, advance
    // the model by one clock edge and wait for that edge.
    task automatic applyStimulus(input bit en, input bit rdy, input bit redir,
                                 input logic [31:0] rpc);
        bit pop;
        bit push;
        enable_i      = en;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
        checkOutput("addr", {32'd0, addr_o}, {32'd0, m_pc});
        checkOutput("valid", {63'd0, instr_valid_o}, {63'd0, (m_count != 0)});
        if (m_count != 0 && exp_q.size() > 0) begin
            m_hold = exp_q[0];
            checkOutput("head_pc", {32'd0, pc_o}, {32'd0, exp_q[0][63:32]});
            checkOutput("head_instr", {32'd0, instr_o}, {32'd0, exp_q[0][31:0]});
        end else begin
            checkOutput("hold", {pc_o, instr_o}, m_hold);
        end
`ifdef IFU_PERF_CNT_EN
        checkOutput("fetch_cnt", {32'd0, fetch_cnt_o}, {32'd0, m_fetch_cnt});
        checkOutput("stall_cnt", {32'd0, stall_cnt_o}, {32'd0, m_stall_cnt});
`endif
        pop = (m_count != 0) && rdy;
        if (m_fetch && m_count == DEPTH && !pop) m_stall_cnt++;
        if (redir) begin
            exp_q.delete();
            m_count = 0;
            m_pc    = {rpc[31:2], 2'b00};
        end else begin
            push = m_fetch && (m_count < DEPTH || pop);
            if (pop) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_count--;
            end
            if (push) begin
                exp_q.push_back({m_pc, mem_word(m_pc)});
                m_count++;
                m_pc = m_pc + 32'd4;
                m_fetch_cnt++;
            end
        end
        m_fetch = en;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i         = 1'b0;
        enable_i      = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_valid", {63'd0, instr_valid_o}, 64'd0);
        checkOutput("rst_pc", {32'd0, pc_o}, 64'd0);
        checkOutput("rst_instr", {32'd0, instr_o}, 64'd0);
        checkOutput("rst_addr", {32'd0, addr_o}, 64'd0);
        rst_i = 1'b1;

        $display("[TB] streaming fetch");
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] backpressure");
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] redirect with full buffer");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h0000_0043);
        checkOutput("redir_valid", {63'd0, instr_valid_o}, 64'd0);
        checkOutput("redir_addr", {32'd0, addr_o}, 64'h40);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] idle and drain");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] wrap at top of address space");
        applyStimulus(1, 1, 1, 32'hFFFF_FFF6);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] stall counting");
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                             : $urandom_range(0, 511);
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 11) == 0, rpc);
        end

        $display("[TB] asynchronous reset while full");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("full_before_rst", {63'd0, instr_valid_o}, 64'd1);
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("arst_valid", {63'd0, instr_valid_o}, 64'd0);
        checkOutput("arst_pc", {32'd0, pc_o}, 64'd0);
        checkOutput("arst_instr", {32'd0, instr_o}, 64'd0);
        checkOutput("arst_addr", {32'd0, addr_o}, 64'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface. Drives a word-aligned fetch address to the instruction memory and captures the returned instruction in the same cycle; memory read is combinational.
- Buffers fetched {pc, instr} pairs in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- Supports stall via backpressure, branch redirect with flush, and run/idle enable.

Parameters:
- ADDR_W, 32, fetch address / PC width.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  fetch permitted when high.
- addr_o  out  ADDR_W  fetch address to instruction memory; always equals fetch_pc.
- instr_i  in  INSTR_W  instruction returned combinationally for addr_o.
- redirect_i  in  1  branch/jump redirect strobe, one cycle.
- redirect_pc_i  in  ADDR_W  redirect target.
- instr_valid_o  out  1  FIFO head valid.
- instr_ready_i  in  1  decode accepts head.
- instr_o  out  INSTR_W  head instruction.
- pc_o  out  ADDR_W  PC of head instruction.

Behaviour:
Reset (rst_i low, asynchronous):
- fetch_pc=RESET_PC, FIFO empty, state=IDLE.
- instr_valid_o=0, instr_o=0, pc_o=0.
- addr_o=RESET_PC.
- Reset mid-operation discards all FIFO contents immediately.

FSM states IDLE, FETCH:
- IDLE→FETCH when enable_i=1.
- FETCH→IDLE when enable_i=0.
- fetch_pc and FIFO contents are retained across IDLE; decode may keep draining in IDLE.
- Redirect is honoured in both states.

Push:
- In FETCH, when FIFO not full, or full and pop in the same cycle, and redirect_i=0: write {fetch_pc, instr_i} at the edge and set fetch_pc += 4.
- Increment wraps modulo 2^ADDR_W (0xFFFF_FFFC → 0).

Pop:
- instr_valid_o && instr_ready_i at the edge removes the head.

Head outputs:
- instr_o/pc_o are driven from the FIFO head, registered; latency 1 cycle from fetch to instr_valid_o.
- When the FIFO is empty, instr_o/pc_o hold their last value and instr_valid_o=0.

Simultaneous events:
- Push and pop on a full FIFO: both occur; count unchanged.
- Pop on empty: ignored (cannot occur, since valid=0).

Redirect (priority over push and pop):
- Clears the FIFO; instr_valid_o=0 the next cycle.
- fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}, low bits forced to zero.
- No push in the redirect cycle.
- The first push of the target occurs the cycle after the redirect, if in FETCH.

Backpressure:
- instr_ready_i=0 with FIFO full: fetch_pc and addr_o hold stable; no push.
- addr_o is always fetch_pc, combinational from the register, glitch-free across stalls.

Optional Feature:
IFU_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0].
  - fetch_cnt_o increments on every push.
  - stall_cnt_o increments on every FETCH cycle with the FIFO full and no pop.
  - Both reset to 0, wrap at 2^32, and are not cleared by redirect.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package ifu_pkg holds:
  - ADDR_W, INSTR_W, RESET_PC defaults.
  - Enum ifu_state_t {IDLE, FETCH}.
  - Struct fetch_entry_t {pc, instr}.
  - Constant PC_STEP=4.
- Sub-module ifu_fifo: synchronous FIFO of fetch_entry_t with push, pop and flush (flush dominant), plus full/empty, async active-low reset.
- Top-level instr_fetch_unit holds the FSM, fetch_pc and the redirect logic.

Test Plan:
Memory model: word k = 32'h1000_0000+k, 128 words, combinational read of addr/4.
- Reset release, enable_i=1, instr_ready_i=1 → first valid next cycle with pc_o=0, instr_o=0x1000_0000; then pc 4, 8, 12, one per cycle.
- instr_ready_i=0 for 5 cycles after 2 fetches → FIFO holds pc 0,4; addr_o holds 8. On ready=1, outputs in order 0, 4, 8 with no gaps or duplicates.
- redirect_i with redirect_pc_i=0x0000_0043 while FIFO holds 2 entries → next cycle instr_valid_o=0, addr_o=0x40; next valid pc_o=0x40, instr_o=0x1000_0010.
- enable_i=0 mid-stream → no further pushes; existing entries drain; addr_o constant. Re-enable resumes at the retained pc.
- Assert rst_i low asynchronously between edges while full → outputs zero immediately, addr_o=RESET_PC.
- With IFU_PERF_CNT_EN: 10 fetches plus 3 full stall cycles → fetch_cnt_o=10, stall_cnt_o=3.
